// File: rtl/instr_fetch_unit.sv
// RV32I instruction fetch stage: sequential PC generation, credit-limited imem requests,
// in-order response buffering with per-request PCs, and redirect flushing of in-flight fetches.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_fault
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    // Stale responses can pile up across back-to-back redirects, so give the counter headroom.
    localparam int SW = CW + 4;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic          halted;
    logic          misalign_pending;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_count;
    logic [SW-1:0] stale;
    logic [PW-1:0] pcq_rd, pcq_wr;
    logic [PW-1:0] fifo_rd, fifo_wr;

    logic [31:0] pcq_mem    [FIFO_DEPTH];
    logic [31:0] fifo_instr [FIFO_DEPTH];
    logic [31:0] fifo_pc    [FIFO_DEPTH];
    logic        fifo_fault [FIFO_DEPTH];

    logic        credit_ok;
    logic        xfer;
    logic        rsp_stale;
    logic        rsp_live;
    logic        misalign_push;
    logic        push;
    logic        pop;
    logic [31:0] push_instr;
    logic [31:0] push_pc;
    logic        push_fault;

    // Every slot in the buffer is pre-reserved by a request, so responses can always be accepted.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_C;
    assign imem_req  = !rst && !redirect_valid && !halted && !misalign_pending && credit_ok;
    assign imem_addr = {fetch_pc[31:2], 2'b00};
    assign xfer      = imem_req && imem_gnt;

    assign rsp_stale     = imem_rvalid && (stale != '0);
    assign rsp_live      = imem_rvalid && (stale == '0) && (outstanding != '0);
    assign misalign_push = misalign_pending && (stale == '0) && !redirect_valid;

    // Decode handshake: an entry transfers on a cycle where id_valid && id_ready; while id_valid is
    // high and id_ready low the head entry is held stable. A redirect overrides the transfer.
    assign push = !redirect_valid && (rsp_live || misalign_push);
    assign pop  = id_valid && id_ready && !redirect_valid;

    always_comb begin
        push_instr = 32'h0;
        push_pc    = fetch_pc;
        push_fault = 1'b1;
        if (rsp_live) begin
            push_instr = imem_err ? 32'h0 : imem_rdata;
            push_pc    = pcq_mem[pcq_rd];
            push_fault = imem_err;
        end
    end

    assign id_valid = (fifo_count != '0);
    assign id_instr = id_valid ? fifo_instr[fifo_rd] : 32'h0;
    assign id_pc    = id_valid ? fifo_pc[fifo_rd]    : 32'h0;
    assign id_fault = id_valid ? fifo_fault[fifo_rd] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc         <= RESET_PC;
            halted           <= 1'b0;
            misalign_pending <= 1'b0;
            outstanding      <= '0;
            stale            <= '0;
            pcq_rd           <= '0;
            pcq_wr           <= '0;
            fifo_rd          <= '0;
            fifo_wr          <= '0;
            fifo_count       <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight becomes stale; a response arriving now is already accounted.
            fetch_pc         <= redirect_pc;
            halted           <= 1'b0;
            misalign_pending <= (redirect_pc[1:0] != 2'b00);
            stale            <= stale + SW'(outstanding) - SW'(rsp_stale || rsp_live);
            outstanding      <= '0;
            pcq_rd           <= '0;
            pcq_wr           <= '0;
            fifo_rd          <= '0;
            fifo_wr          <= '0;
            fifo_count       <= '0;
        end else begin
            if (xfer) begin
                fetch_pc <= fetch_pc + 32'd4;
                pcq_wr   <= pcq_wr + PW'(1);
            end
            if (rsp_stale) stale <= stale - SW'(1);
            if (rsp_live) pcq_rd <= pcq_rd + PW'(1);
            case ({xfer, rsp_live})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: ;
            endcase
            if ((rsp_live && imem_err) || misalign_push) halted <= 1'b1;
            if (misalign_push) misalign_pending <= 1'b0;
            if (push) fifo_wr <= fifo_wr + PW'(1);
            if (pop) fifo_rd <= fifo_rd + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) pcq_mem[pcq_wr] <= imem_addr;
        if (push) begin
            fifo_instr[fifo_wr] <= push_instr;
            fifo_pc[fifo_wr]    <= push_pc;
            fifo_fault[fifo_wr] <= push_fault;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model, expected-entry queue, redirect vector table,
// plus hand sequences for latency, back-pressure, access fault, double redirect and mid-run reset.
module tb_instr_fetch_unit;

    localparam int          W   = 65;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_fault;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .id_fault(id_fault)
    );

    always #5 clk = ~clk;

    // Scoreboard: {instr, pc, fault} in the order decode must see them.
    logic [W-1:0] exp_q[$];
    logic [32:0]  mem_q[$];
    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int first_gnt = -1;
    int first_valid = -1;
    int ready_pct = 100;
    int gnt_pct = 100;
    int rsp_pct = 100;
    bit hold_rsp = 1'b0;
    bit err_en = 1'b0;
    bit do_redirect = 1'b0;
    bit prev_redirect = 1'b0;
    logic [31:0] err_addr = 32'h8;
    logic [31:0] do_redirect_pc = 32'h0;
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] last_fault_pc = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] target;
        int          pre;
        bit          hold;
        logic [31:0] first_pc;
        logic        first_fault;
    } vec_t;
    vec_t vec[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_err = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
        mem_q.delete(); exp_q.delete();
        exp_addr = 32'h0; prev_redirect = 1'b0; do_redirect = 1'b0;
        first_gnt = -1; first_valid = -1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_imem_req", imem_req, 0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_id_valid", id_valid, 0);
        check("rst_id_instr", id_instr, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_fault", id_fault, 0);
        rst = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge, sample just after, update the model.
    task automatic step();
        logic [32:0]  m;
        logic [W-1:0] e;
        logic         err;
        @(negedge clk);
        redirect_valid = do_redirect;
        redirect_pc = do_redirect_pc;
        do_redirect = 1'b0;
        id_ready = ($urandom_range(99) < ready_pct);
        imem_gnt = ($urandom_range(99) < gnt_pct);
        if (mem_q.size() > 0 && !hold_rsp && $urandom_range(99) < rsp_pct) begin
            m = mem_q.pop_front();
            imem_rvalid = 1'b1;
            imem_err = m[32];
            imem_rdata = m[32] ? $urandom() : (m[31:0] ^ KEY);
        end else begin
            imem_rvalid = 1'b0;
            imem_err = 1'($urandom_range(1));
            imem_rdata = $urandom();
        end
        #1;
        cyc++;
        if (prev_redirect) check("id_valid_after_redirect", id_valid, 0);
        prev_redirect = redirect_valid;
        if (first_valid < 0 && id_valid) first_valid = cyc;
        if (redirect_valid) begin
            check("req_during_redirect", imem_req, 0);
            exp_q.delete();
            exp_addr = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) exp_q.push_back({32'h0, redirect_pc, 1'b1});
        end else begin
            if (id_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_id: got pc 0x%0h, expected no entry", id_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("id_instr", id_instr, e[64:33]);
                    check("id_pc", id_pc, e[32:1]);
                    check("id_fault", id_fault, e[0]);
                    if (id_fault) last_fault_pc = id_pc;
                end
            end
            if (imem_req) begin
                check("imem_addr", imem_addr, exp_addr);
                if (imem_gnt) begin
                    if (first_gnt < 0) first_gnt = cyc;
                    err = err_en && (exp_addr == err_addr);
                    mem_q.push_back({err, exp_addr});
                    exp_q.push_back({err ? 32'h0 : (exp_addr ^ KEY), exp_addr, err});
                    exp_addr = exp_addr + 32'd4;
                end
            end
        end
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_err = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
        vec[0] = '{32'h0000_0100, 6, 1'b1, 32'h0000_0100, 1'b0};
        vec[1] = '{32'h0000_0200, 5, 1'b0, 32'h0000_0200, 1'b0};
        vec[2] = '{32'h0000_0102, 4, 1'b0, 32'h0000_0102, 1'b1};
        vec[3] = '{32'hFFFF_FFFC, 3, 1'b0, 32'hFFFF_FFFC, 1'b0};
        vec[4] = '{32'h0000_0040, 4, 1'b1, 32'h0000_0040, 1'b0};

        do_reset();

        // Streaming from reset.
        repeat (20) step();
        check("first_valid_latency", 64'(first_valid - first_gnt), 64'd2);

        // Back-pressure: head must hold and requests must stop on credit.
        ready_pct = 0;
        repeat (10) begin
            step();
            if (id_valid && exp_q.size() > 0) check("head_hold_pc", id_pc, exp_q[0][32:1]);
        end
        check("backpressure_req", imem_req, 0);
        check("backpressure_valid", id_valid, 1);
        ready_pct = 100;
        repeat (10) step();

        // Redirect table.
        for (int i = 0; i < 5; i++) begin
            hold_rsp = vec[i].hold;
            repeat (vec[i].pre) step();
            hold_rsp = 1'b0;
            do_redirect = 1'b1;
            do_redirect_pc = vec[i].target;
            step();
            found = 1'b0;
            for (int k = 0; k < 30 && !found; k++) begin
                step();
                if (id_valid) found = 1'b1;
            end
            if (found) begin
                check("vec_first_pc", id_pc, vec[i].first_pc);
                check("vec_first_fault", id_fault, vec[i].first_fault);
            end else begin
                checks++;
                $display("FAIL vec_timeout: vector %0d got no id_valid, expected pc 0x%0h", i, vec[i].first_pc);
            end
            if (vec[i].first_fault) begin
                repeat (5) begin
                    step();
                    check("misaligned_no_req", imem_req, 0);
                end
            end
            repeat (6) step();
        end

        // Second redirect while the first one's responses are still stale.
        hold_rsp = 1'b1;
        repeat (4) step();
        do_redirect = 1'b1; do_redirect_pc = 32'h0000_0300;
        step();
        repeat (3) step();
        do_redirect = 1'b1; do_redirect_pc = 32'h0000_0400;
        step();
        hold_rsp = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            if (id_valid) found = 1'b1;
        end
        if (found) check("double_redirect_pc", id_pc, 32'h0000_0400);
        else begin
            checks++;
            $display("FAIL double_redirect_timeout: got no id_valid, expected pc 0x400");
        end
        repeat (10) step();

        // Access fault on the response for 0x8.
        do_reset();
        err_en = 1'b1;
        repeat (12) step();
        repeat (8) begin
            step();
            check("fault_halt_req", imem_req, 0);
        end
        check("fault_pc", last_fault_pc, 32'h8);
        check("fault_drained", exp_q.size(), 0);
        err_en = 1'b0;
        do_redirect = 1'b1; do_redirect_pc = 32'h0000_0100;
        repeat (12) step();

        // Random traffic with occasional redirects.
        gnt_pct = 70; ready_pct = 60; rsp_pct = 70;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(39) == 0) begin
                do_redirect = 1'b1;
                do_redirect_pc = $urandom() & 32'h0000_FFFC;
                if ($urandom_range(5) == 0) do_redirect_pc = do_redirect_pc | 32'h2;
            end
            step();
        end

        // Reset in the middle of traffic, then resume.
        do_reset();
        gnt_pct = 100; ready_pct = 100; rsp_pct = 100;
        repeat (12) step();

        // Drain everything still in flight.
        gnt_pct = 0;
        repeat (10) step();
        check("final_exp_empty", exp_q.size(), 0);
        check("final_mem_empty", mem_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
